// File: rtl/mux_sel_sequencer.sv
// Select-line sequencer for the 3-bit 2:1 data mux: a debounced pushbutton
// and an optional auto timer each toggle s; toggles are counted.
module mux_sel_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned AUTO_PERIOD     = 100_000_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             auto_en,
  input  logic             hold,
  output logic             s,
  output logic             s_changed,
  output logic [CNT_W-1:0] toggle_count
);

  localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AT_W  = $clog2(AUTO_PERIOD);

  // IDLE sees the first stable sample, so ARM_P/ARM_R only need D-1 more.
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [AT_W-1:0]  AT_LAST  = AT_W'(AUTO_PERIOD - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM_P = 3'd1;
  localparam logic [2:0] PRESS = 3'd2;
  localparam logic [2:0] HELD  = 3'd3;
  localparam logic [2:0] ARM_R = 3'd4;

  logic             btn_m, btn_s;
  logic [2:0]       state, state_nxt;
  logic [DBC_W-1:0] dbc, dbc_nxt;
  logic [AT_W-1:0]  at, at_nxt;
  logic             press_evt, auto_tick, tgl;

  // two-flop synchroniser for the raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  always_comb begin
    state_nxt = state;
    dbc_nxt   = dbc;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARM_P;
          dbc_nxt   = '0;
        end
      end
      ARM_P: begin
        if (!btn_s)              state_nxt = IDLE;
        else if (dbc == DBC_LAST) state_nxt = PRESS;
        else                     dbc_nxt   = dbc + 1'b1;
      end
      PRESS: state_nxt = HELD;
      HELD: begin
        if (!btn_s) begin
          state_nxt = ARM_R;
          dbc_nxt   = '0;
        end
      end
      ARM_R: begin
        if (btn_s)               state_nxt = HELD;
        else if (dbc == DBC_LAST) state_nxt = IDLE;
        else                     dbc_nxt   = dbc + 1'b1;
      end
      default: state_nxt = HELD;
    endcase
  end

  // Reset lands in HELD so a button held through reset never toggles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HELD;
      dbc   <= '0;
    end else begin
      state <= state_nxt;
      dbc   <= dbc_nxt;
    end
  end

  assign press_evt = (state == PRESS);
  assign auto_tick = auto_en & (at == AT_LAST);
  assign tgl       = (press_evt | auto_tick) & ~hold;

  // Any accepted toggle (press or tick) restarts the period.
  always_comb begin
    at_nxt = at;
    if (!auto_en)  at_nxt = '0;
    else if (hold) at_nxt = at;
    else if (tgl)  at_nxt = '0;
    else           at_nxt = at + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      at           <= '0;
      s            <= 1'b0;
      s_changed    <= 1'b0;
      toggle_count <= '0;
    end else begin
      at        <= at_nxt;
      s_changed <= tgl;
      if (tgl) begin
        s            <= ~s;
        toggle_count <= toggle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with short debounce/auto periods.
module tb_mux_sel_sequencer;

  localparam int unsigned CNT_W = 3;

  logic             clk, reset, btn, auto_en, hold;
  logic             s, s_changed;
  logic [CNT_W-1:0] toggle_count;

  int total = 0;
  int bad   = 0;
  int chg_cnt;
  int chg_edge [$];

  mux_sel_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (10),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .auto_en     (auto_en),
    .hold        (hold),
    .s           (s),
    .s_changed   (s_changed),
    .toggle_count(toggle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance n edges, sample 1ns after each, tally s_changed pulses
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (s_changed) chg_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic press(input int k);
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(10);
    chk($sformatf("t6_cnt_%0d", k), toggle_count, k % 8);
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; auto_en = 1'b0; hold = 1'b0; chg_cnt = 0;
    step(2);
    chk("rst_s", s, 0);
    chk("rst_chg", s_changed, 0);
    chk("rst_cnt", toggle_count, 0);
    reset = 1'b0;

    // 1: clean press, s flips 7 edges after btn rises
    step(10);
    btn = 1'b1;
    step(6);
    chk("t1_s_early", s, 0);
    step(1);
    chk("t1_s", s, 1);
    chk("t1_chg", s_changed, 1);
    chk("t1_cnt", toggle_count, 1);
    step(1);
    chk("t1_chg_off", s_changed, 0);

    // 2: short bounces produce nothing
    btn = 1'b0;
    step(10);
    chg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; step(2);
      btn = 1'b0; step(2);
    end
    step(10);
    chk("t2_chg", chg_cnt, 0);
    chk("t2_s", s, 1);
    chk("t2_cnt", toggle_count, 1);

    // 3: button held across reset release
    reset = 1'b1; btn = 1'b1;
    step(3);
    reset = 1'b0; chg_cnt = 0;
    step(50);
    chk("t3_chg", chg_cnt, 0);
    chk("t3_s", s, 0);
    chk("t3_cnt", toggle_count, 0);
    btn = 1'b0;
    step(10);

    // 4: auto mode, toggles at edges 10/20/30
    do_reset();
    step(10);
    chg_cnt = 0;
    auto_en = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step(1);
      if (s_changed) chg_edge.push_back(i);
    end
    auto_en = 1'b0;
    chk("t4_ntgl", chg_edge.size(), 3);
    if (chg_edge.size() == 3) begin
      chk("t4_e0", chg_edge[0], 10);
      chk("t4_e1", chg_edge[1], 20);
      chk("t4_e2", chg_edge[2], 30);
    end
    chk("t4_s", s, 1);
    chk("t4_cnt", toggle_count, 3);

    // 5: hold freezes timer at 4; resumes and ticks 6 edges after release
    do_reset();
    step(10);
    auto_en = 1'b1;
    step(4);
    hold = 1'b1; chg_cnt = 0;
    step(25);
    chk("t5_hold_chg", chg_cnt, 0);
    chk("t5_hold_s", s, 0);
    hold = 1'b0;
    step(5);
    chk("t5_s_early", s, 0);
    step(1);
    chk("t5_chg", s_changed, 1);
    chk("t5_s", s, 1);
    chk("t5_cnt", toggle_count, 1);
    auto_en = 1'b0;

    // 6: nine presses wrap the 3-bit count, then async reset mid ARM_P
    do_reset();
    step(10);
    for (int k = 1; k <= 9; k++) press(k);
    chk("t6_s", s, 1);
    btn = 1'b1;
    step(4);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_s", s, 0);
    chk("t6_rst_cnt", toggle_count, 0);
    chk("t6_rst_chg", s_changed, 0);
    step(1);
    reset = 1'b0;
    step(20);
    chk("t6_after_cnt", toggle_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
